step_input_conditioner: RTL and testbench
=========================================

STEP_INPUT_CONDITIONER -- requirements
Module: step_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a press or release; legal range is 2 or more.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 16: cycles from the accepted-press step to the first auto-repeat step; legal range is 2 or more.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 8: cycles between consecutive auto-repeat steps; legal range is 2 or more.
REQ-004 Port clk SHALL be an input, 1 bit wide: the system clock; all state updates on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit wide: reset, asynchronous, active-high.
REQ-006 Port btn_raw SHALL be an input, 1 bit wide: the raw, asynchronous, bouncing step push-button (1 = pressed).
REQ-007 Port dir_raw SHALL be an input, 1 bit wide: the raw, asynchronous direction switch (0 = UP, 1 = DOWN).
REQ-008 Port step SHALL be an output, 1 bit wide: a one-cycle count-enable pulse for the downstream up/down counter.
REQ-009 Port dir SHALL be an output, 1 bit wide: the registered direction, valid and stable whenever step = 1.
REQ-010 Port held SHALL be an output, 1 bit wide: 1 while a debounced press is in effect.

Function
REQ-011 btn_raw and dir_raw SHALL each pass through a 2-flop synchronizer (outputs btn_s, dir_s) before any other logic sees them.
REQ-012 The FSM SHALL have exactly five states: IDLE, PRESS_DB, PRESSED, REPEAT, RELEASE_DB.
REQ-013 A single down-counter SHALL time all FSM intervals.
  - Its width SHALL be $clog2 of the largest parameter, plus 1.
  - It SHALL be reloaded on every state transition.
REQ-014 In IDLE, btn_s = 1 SHALL move the FSM to PRESS_DB; otherwise the FSM SHALL stay in IDLE.
REQ-015 In PRESS_DB, btn_s = 0 in any cycle SHALL return the FSM to IDLE with no step (glitch rejection).
REQ-016 In PRESS_DB, after DEBOUNCE_CYCLES consecutive cycles of btn_s = 1, the FSM SHALL enter PRESSED and assert step for exactly one cycle.
REQ-017 In PRESSED, btn_s = 0 SHALL move the FSM to RELEASE_DB.
REQ-018 In PRESSED, if btn_s stays 1 for REPEAT_DELAY cycles after the press step, the FSM SHALL enter REPEAT and assert step for one cycle.
REQ-019 In REPEAT, step SHALL assert for one cycle every REPEAT_PERIOD cycles while btn_s = 1; btn_s = 0 SHALL move the FSM to RELEASE_DB with no step.
REQ-020 In RELEASE_DB, after DEBOUNCE_CYCLES consecutive cycles of btn_s = 0, the FSM SHALL enter IDLE.
REQ-021 In RELEASE_DB, btn_s = 1 SHALL return the FSM to PRESSED with the REPEAT_DELAY timer restarted and no step (bounce on release never double-steps).
REQ-022 step SHALL be registered and glitch-free; it SHALL never be high on two consecutive cycles.
REQ-023 dir SHALL be loaded from dir_s on the same edge that raises step, and SHALL hold its value at all other times.
  - A direction change mid-hold SHALL take effect on the next step.
REQ-024 held SHALL be 1 in PRESSED, REPEAT and RELEASE_DB, and 0 in IDLE and PRESS_DB.
REQ-025 Latency: with btn_raw first sampled high at edge 1 and held clean, step SHALL be high in the cycle after edge DEBOUNCE_CYCLES+2.

Reset
REQ-026 While reset = 1, the FSM SHALL be in IDLE; the counter, both synchronizers, step, dir and held SHALL all be 0, independent of clk.
REQ-027 Reset asserted mid-press or mid-repeat SHALL abort immediately with no further step.
  - A button still held at reset release SHALL be re-debounced and SHALL yield exactly one new step after DEBOUNCE_CYCLES+2 edges.

Verification (defaults DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8)
REQ-028 Clean press: btn_raw rises before edge 1 and is held 10 cycles, then released -> step is high only in the cycle after edge 6, dir = dir_raw at that time, held rises with step.
REQ-029 Bounce: btn_raw toggles 1,0,1,0,1 on successive cycles, then stays high -> no step during the bounce; exactly one step, 6 edges after the final rise.
REQ-030 Auto-repeat: hold btn_raw 60 cycles -> steps at edges 6, 22, 30, 38, 46, 54 (relative), then none after release; held falls 4 cycles after btn_s falls.
REQ-031 Release bounce: during RELEASE_DB, btn_raw goes 1 for 2 cycles then 0 -> no extra step; held stays 1 until 4 clean low cycles have elapsed.
REQ-032 Direction: during auto-repeat, flip dir_raw 1 -> 0 between two steps -> dir changes exactly on the next step edge, never between steps.
REQ-033 Reset mid-repeat: assert reset asynchronously between two clock edges -> step, held and dir go to 0 immediately; with the button still held, the first step appears 6 edges after reset release.

Source files
------------

// File: rtl/step_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : step_input_conditioner
// Purpose : Synchronises, debounces and auto-repeats a step push-button,
//           producing one-cycle count-enable pulses with a latched direction.
// Rev     : 1.0  initial release
// ============================================================================
module step_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic dir_raw,
    output logic step,
    output logic dir,
    output logic held
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    // The cycle in which the previous state first sees the new btn_s level
    // counts toward the debounce window, hence the -2 rather than -1.
    localparam logic [CNT_W-1:0] DB_LOAD     = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        PRESSED    = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_meta_q, btn_meta_d;
    logic             btn_s_q, btn_s_d;
    logic             dir_meta_q, dir_meta_d;
    logic             dir_s_q, dir_s_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             held_q, held_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            dir_meta_q <= 1'b0;
            dir_s_q    <= 1'b0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_meta_q <= btn_meta_d;
            btn_s_q    <= btn_s_d;
            dir_meta_q <= dir_meta_d;
            dir_s_q    <= dir_s_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            held_q     <= held_d;
        end
    end

    always_comb begin
        btn_meta_d = btn_raw;
        btn_s_d    = btn_meta_q;
        dir_meta_d = dir_raw;
        dir_s_d    = dir_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS_DB;
                    cnt_d   = DB_LOAD;
                end
            end
            PRESS_DB: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = PRESSED;
                    cnt_d   = DELAY_LOAD;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_DB;
                    cnt_d   = DB_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = REPEAT;
                    cnt_d   = PERIOD_LOAD;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            REPEAT: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_DB;
                    cnt_d   = DB_LOAD;
                end else if (cnt_q == '0) begin
                    cnt_d  = PERIOD_LOAD;
                    step_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RELEASE_DB: begin
                // A bounce back to pressed re-arms the repeat delay without stepping.
                if (btn_s_q) begin
                    state_d = PRESSED;
                    cnt_d   = DELAY_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        dir_d  = step_d ? dir_s_q : dir_q;
        held_d = (state_d == PRESSED) || (state_d == REPEAT) || (state_d == RELEASE_DB);
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign held = held_q;

endmodule
`default_nettype wire

// File: tb/tb_step_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_step_input_conditioner
// Purpose : Scoreboard bench: stimulus queues expected steps, monitor checks.
// Rev     : 1.0  initial release
// ============================================================================
module tb_step_input_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_raw = 1'b0;
    logic dir_raw = 1'b0;
    logic step, dir, held;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;

    exp_t exp_q[$];

    step_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (16),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .dir_raw(dir_raw),
        .step   (step),
        .dir    (dir),
        .held   (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_step(input int c, input logic d);
        exp_t e;
        e.cyc = c;
        e.dir = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every step pulse must match the head of the expectation queue.
    logic prev_step = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_step = 1'b0;
        end else begin
            if (step) begin
                chk("step_not_back_to_back", int'(prev_step), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_step", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("step_cycle", cyc, e.cyc);
                    chk("step_dir", int'(dir), int'(e.dir));
                    chk("held_with_step", int'(held), 1);
                end
            end
            prev_step = step;
        end
    end

    initial begin
        int base;
        int r;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_step", int'(step), 0);
        chk("rst_held", int'(held), 0);
        chk("rst_dir", int'(dir), 0);
        reset = 1'b0;
        goto_cyc(cyc + 5);
        chk("idle_held", int'(held), 0);

        // Clean press, dir = DOWN
        dir_raw = 1'b1;
        base = cyc;
        btn_raw = 1'b1;
        push_step(base + 6, 1'b1);
        goto_cyc(base + 5);
        chk("clean_held_before", int'(held), 0);
        goto_cyc(base + 6);
        chk("clean_held_rise", int'(held), 1);
        goto_cyc(base + 10);
        btn_raw = 1'b0;
        goto_cyc(base + 30);
        chk("clean_held_after", int'(held), 0);

        // Bounce 1,0,1,0,1 then steady high, dir = UP
        dir_raw = 1'b0;
        base = cyc;
        btn_raw = 1'b1; goto_cyc(base + 1);
        btn_raw = 1'b0; goto_cyc(base + 2);
        btn_raw = 1'b1; goto_cyc(base + 3);
        btn_raw = 1'b0; goto_cyc(base + 4);
        btn_raw = 1'b1;
        base = cyc;
        push_step(base + 6, 1'b0);
        goto_cyc(base + 5);
        chk("bounce_held_before", int'(held), 0);
        goto_cyc(base + 10);
        btn_raw = 1'b0;
        goto_cyc(base + 30);

        // Auto-repeat with a direction flip between the 30 and 38 steps
        dir_raw = 1'b1;
        base = cyc;
        btn_raw = 1'b1;
        push_step(base + 6, 1'b1);
        push_step(base + 22, 1'b1);
        push_step(base + 30, 1'b1);
        push_step(base + 38, 1'b0);
        push_step(base + 46, 1'b0);
        push_step(base + 54, 1'b0);
        goto_cyc(base + 33);
        dir_raw = 1'b0;
        goto_cyc(base + 37);
        chk("dir_holds_between_steps", int'(dir), 1);
        goto_cyc(base + 38);
        chk("dir_changes_on_step", int'(dir), 0);
        goto_cyc(base + 58);
        btn_raw = 1'b0;
        goto_cyc(base + 63);
        chk("repeat_held_last", int'(held), 1);
        goto_cyc(base + 64);
        chk("repeat_held_fall", int'(held), 0);
        goto_cyc(base + 80);

        // Release bounce during RELEASE_DB
        base = cyc;
        btn_raw = 1'b1;
        push_step(base + 6, 1'b0);
        goto_cyc(base + 10);
        btn_raw = 1'b0;
        goto_cyc(base + 12);
        btn_raw = 1'b1;
        goto_cyc(base + 14);
        btn_raw = 1'b0;
        goto_cyc(base + 19);
        chk("relbounce_held_last", int'(held), 1);
        goto_cyc(base + 20);
        chk("relbounce_held_fall", int'(held), 0);
        goto_cyc(base + 40);

        // Asynchronous reset during the first repeat step, button kept held
        dir_raw = 1'b1;
        base = cyc;
        btn_raw = 1'b1;
        push_step(base + 6, 1'b1);
        push_step(base + 22, 1'b1);
        goto_cyc(base + 22);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_step", int'(step), 0);
        chk("async_rst_held", int'(held), 0);
        chk("async_rst_dir", int'(dir), 0);
        goto_cyc(base + 24);
        reset = 1'b0;
        r = cyc;
        push_step(r + 6, 1'b1);
        goto_cyc(r + 5);
        chk("post_rst_held_before", int'(held), 0);
        goto_cyc(r + 10);
        btn_raw = 1'b0;
        goto_cyc(r + 30);
        chk("post_rst_held_after", int'(held), 0);

        chk("missing_steps", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
